// File: rtl/screen_pkg.sv
// Shared screen geometry, colour width and the frame sequencer's state encoding.
// Imported by the frame painter and its raster counter.
package screen_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int COLOUR_W  = 3;
  localparam int TIMEOUT_W = 27;

  localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LAUNCH = 3'd2,
    DRAW   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major x/y scanner over a W x H frame.
// Advances one pixel per enabled cycle and wraps to (0,0) after the last pixel.
module raster_counter
  import screen_pkg::*;
#(
  parameter int W = SCREEN_W,
  parameter int H = SCREEN_H
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(H - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_painter.sv
// Frame sequencer: clears the frame buffer, launches one shape drawer and forwards
// its pixels in the latched foreground colour, owning the single vga_adapter port.
module frame_painter
  import screen_pkg::*;
#(
  parameter int DRAW_TIMEOUT = 67_108_863
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [X_W-1:0]      shape_x,
  input  logic [Y_W-1:0]      shape_y,
  input  logic                shape_plot,
  input  logic                shape_done,
  output logic                shape_start,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                frame_done,
  output logic                error
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(DRAW_TIMEOUT);

  state_t                state;
  logic [COLOUR_W-1:0]   fg_q;
  logic [TIMEOUT_W-1:0]  timeout_cnt;
  logic [TIMEOUT_W-1:0]  timeout_next;
  logic                  clear_plot;
  logic                  raster_en;
  logic                  raster_last;
  logic [X_W-1:0]        raster_x;
  logic [Y_W-1:0]        raster_y;

  assign raster_en    = (state == CLEAR);
  assign timeout_next = timeout_cnt + TIMEOUT_W'(1);
  assign busy         = (state != IDLE);

  raster_counter #(
    .W (SCREEN_W),
    .H (SCREEN_H)
  ) u_raster (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (raster_en),
    .x       (raster_x),
    .y       (raster_y),
    .last    (raster_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      fg_q        <= BG_COLOUR;
      timeout_cnt <= '0;
      clear_plot  <= 1'b0;
      shape_start <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      shape_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fg_q       <= fg_colour;
            error      <= 1'b0;
            clear_plot <= 1'b1;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          if (raster_last) begin
            clear_plot  <= 1'b0;
            shape_start <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          timeout_cnt <= '0;
          state       <= DRAW;
        end
        DRAW: begin
          // A done seen on the timeout cycle still completes the frame.
          if (shape_done) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else if (timeout_next == TIMEOUT_LIMIT) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            timeout_cnt <= timeout_next;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The raster counter rests at (0,0) outside CLEAR, so it also supplies the idle position.
  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    x      = raster_x;
    y      = raster_y;
    plot   = clear_plot;
    colour = BG_COLOUR;
    if (state == DRAW) begin
      x      = shape_x;
      y      = shape_y;
      plot   = shape_plot;
      colour = fg_q;
    end
  end

endmodule

// File: tb/tb_frame_painter.sv
// Scoreboard bench for frame_painter: expected pixels are queued as stimulus is
// driven and compared whenever the painter asserts plot.
module tb_frame_painter;
  import screen_pkg::*;

  localparam int TIMEOUT = 100;
  localparam int NPIX    = SCREEN_W * SCREEN_H;
  localparam int BUDGET  = 25_000;

  typedef struct packed {
    logic [X_W-1:0]      px;
    logic [Y_W-1:0]      py;
    logic [COLOUR_W-1:0] pc;
  } pix_t;

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [COLOUR_W-1:0] fg_colour;
  logic [X_W-1:0]      shape_x;
  logic [Y_W-1:0]      shape_y;
  logic                shape_plot;
  logic                shape_done;
  logic                shape_start;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                frame_done;
  logic                error;

  pix_t exp_q[$];
  pix_t mon_p;
  int   n_checks     = 0;
  int   n_pass       = 0;
  int   start_pulses = 0;
  int   done_pulses  = 0;
  int   n;

  frame_painter #(.DRAW_TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .fg_colour   (fg_colour),
    .shape_x     (shape_x),
    .shape_y     (shape_y),
    .shape_plot  (shape_plot),
    .shape_done  (shape_done),
    .shape_start (shape_start),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .frame_done  (frame_done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_pix(input logic [X_W-1:0] px, input logic [Y_W-1:0] py,
                          input logic [COLOUR_W-1:0] pc);
    pix_t p;
    p.px = px;
    p.py = py;
    p.pc = pc;
    exp_q.push_back(p);
  endtask

  // Queue the first npix clear-pass pixels in raster order, then pulse start for one edge.
  task automatic accept_start(input logic [COLOUR_W-1:0] fg, input int npix);
    @(posedge clk) #1;
    start     = 1'b1;
    fg_colour = fg;
    for (int i = 0; i < npix; i++)
      push_pix(X_W'(i % SCREEN_W), Y_W'(i / SCREEN_W), BG_COLOUR);
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  // Count edges after the accepting edge until shape_start is seen (bounded).
  task automatic wait_launch(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (shape_start !== 1'b1 && cnt < BUDGET) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
  endtask

  // Start a frame, reset it while pixel npix-1 is on the port, then verify the idle state.
  task automatic run_partial(input logic [COLOUR_W-1:0] fg, input int npix);
    accept_start(fg, npix);
    repeat (npix - 1) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk) #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_plot", plot, 1'b0);
    check("rst_x", x, '0);
    check("rst_y", y, '0);
    check("rst_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (shape_start === 1'b1) start_pulses++;
    if (frame_done === 1'b1) done_pulses++;
    if (plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_plot", plot, 1'b0);
      end else begin
        mon_p = exp_q.pop_front();
        check("pixel", 32'({x, y, colour}), 32'(mon_p));
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    fg_colour  = '0;
    shape_x    = 8'd5;
    shape_y    = 7'd7;
    shape_plot = 1'b1;
    shape_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_plot", plot, 1'b0);
    check("reset_x", x, '0);
    check("reset_y", y, '0);
    check("reset_colour", colour, BG_COLOUR);
    check("reset_error", error, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_shape_start", shape_start, 1'b0);
    @(posedge clk) #1;
    reset_n = 1'b1;

    // Full clear with the drawer strobing throughout, then launch.
    accept_start(3'b100, NPIX);
    wait_launch(n);
    check("launch_latency", n, NPIX);
    check("clear_left", exp_q.size(), 0);
    check("launch_plot", plot, 1'b0);
    check("launch_busy", busy, 1'b1);

    // Draw passthrough: a fixed pixel then a few random ones.
    @(posedge clk) #1;
    shape_x = 8'd79;
    shape_y = 7'd63;
    push_pix(8'd79, 7'd63, 3'b100);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1;
      shape_x    = X_W'($urandom_range(0, SCREEN_W - 1));
      shape_y    = Y_W'($urandom_range(0, SCREEN_H - 1));
      shape_plot = 1'($urandom_range(0, 1));
      if (shape_plot) push_pix(shape_x, shape_y, 3'b100);
    end
    @(posedge clk) #1;
    shape_plot = 1'b0;
    shape_done = 1'b1;
    @(negedge clk);
    check("draw_fd_early", frame_done, 1'b0);
    check("draw_busy", busy, 1'b1);
    @(posedge clk) #1;
    shape_done = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    check("done_pulse", frame_done, 1'b1);
    check("done_plot", plot, 1'b0);
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_fd", frame_done, 1'b0);
    check("idle_error", error, 1'b0);
    check("idle_x", x, '0);
    check("idle_y", y, '0);
    repeat (3) @(negedge clk);
    check("done_start_ignored", busy, 1'b0);
    check("f1_launches", start_pulses, 1);
    check("f1_frames", done_pulses, 1);

    // Timeout: drawer never reports done.
    accept_start(3'b001, NPIX);
    wait_launch(n);
    check("t_launch_latency", n, NPIX);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (error !== 1'b1 && n < 4 * TIMEOUT);
    check("timeout_cycles", n, TIMEOUT + 1);
    check("timeout_busy", busy, 1'b0);
    check("timeout_frames", done_pulses, 1);

    // Next start clears error; a mid-clear start is ignored; done held as a level.
    shape_done = 1'b1;
    accept_start(3'b011, NPIX);
    check("error_cleared", error, 1'b0);
    fork
      begin
        repeat (500) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
      end
    join_none
    wait_launch(n);
    check("l_launch_latency", n, NPIX);
    @(posedge clk);
    @(negedge clk);
    check("l_draw_fd", frame_done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("l_done_pulse", frame_done, 1'b1);
    @(posedge clk) #1;
    shape_done = 1'b0;
    repeat (3) @(negedge clk);
    check("l_busy", busy, 1'b0);
    check("l_error", error, 1'b0);
    check("l_launches", start_pulses, 3);
    check("l_frames", done_pulses, 3 - 1);

    // Reset at clear pixel (40,10), then a fresh start restarts from (0,0).
    run_partial(3'b110, 10 * SCREEN_W + 40 + 1);
    run_partial(3'b101, 11);
    check("r_launches", start_pulses, 3);
    check("r_frames", done_pulses, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
